// File: rtl/multicycle_alu.sv
// Multi-cycle ALU: single-cycle logic/arith ops, iterative shift-add multiply
// and restoring divide, with a registered result and one-cycle ready pulse.
module multicycle_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             start,
  input  logic [5:0]       aluctl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] alu_out_data,
  output logic             alu_ready,
  output logic             busy,
  output logic             overflow,
  output logic             div_by_zero,
  output logic             illegal_op,
  output logic             zero
);

  localparam int CW  = $clog2(WIDTH);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [5:0] OP_ADD  = 6'd0;
  localparam logic [5:0] OP_ADDU = 6'd1;
  localparam logic [5:0] OP_SUB  = 6'd2;
  localparam logic [5:0] OP_SUBU = 6'd3;
  localparam logic [5:0] OP_AND  = 6'd4;
  localparam logic [5:0] OP_OR   = 6'd5;
  localparam logic [5:0] OP_XOR  = 6'd6;
  localparam logic [5:0] OP_NOR  = 6'd7;
  localparam logic [5:0] OP_SLT  = 6'd8;
  localparam logic [5:0] OP_SLL  = 6'd9;
  localparam logic [5:0] OP_SRL  = 6'd10;
  localparam logic [5:0] OP_SRA  = 6'd11;
  localparam logic [5:0] OP_MUL  = 6'd12;
  localparam logic [5:0] OP_DIV  = 6'd13;

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             ovf_q, ovf_d;
  logic             dbz_q, dbz_d;
  logic             ill_q, ill_d;
  logic             zero_q, zero_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             neg_q, neg_d;
  // opa: multiplicand / dividend-then-quotient; opb: multiplier / divisor
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  // acc: product accumulator / partial remainder (extra bit for the borrow)
  logic [WIDTH:0]   acc_q, acc_d;

  logic [WIDTH-1:0] sum, dif, abs_a, abs_b, sc_res, madd, mres, fres;
  logic [WIDTH:0]   rem_sh, rem_dif;
  logic [SHW-1:0]   shamt;
  logic             sc_ovf, sc_ill, accept, last, ge;

  assign sum    = A + B;
  assign dif    = A - B;
  assign shamt  = B[SHW-1:0];
  assign abs_a  = A[WIDTH-1] ? (~A + 1'b1) : A;
  assign abs_b  = B[WIDTH-1] ? (~B + 1'b1) : B;
  assign accept = start && (state_q == S_IDLE || state_q == S_DONE);
  assign last   = (cnt_q == CW'(WIDTH - 1));

  assign madd    = acc_q[WIDTH-1:0] + (opb_q[0] ? opa_q : '0);
  assign mres    = neg_q ? (~madd + 1'b1) : madd;
  assign rem_sh  = {acc_q[WIDTH-1:0], opa_q[WIDTH-1]};
  assign rem_dif = rem_sh - {1'b0, opb_q};
  assign ge      = ~rem_dif[WIDTH];
  assign fres    = neg_q ? (~opa_q + 1'b1) : opa_q;

  always_comb begin
    sc_res = '0;
    sc_ovf = 1'b0;
    sc_ill = 1'b0;
    case (aluctl)
      OP_ADD: begin
        sc_res = sum;
        sc_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_ADDU: sc_res = sum;
      OP_SUB: begin
        sc_res = dif;
        sc_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (dif[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUBU: sc_res = dif;
      OP_AND:  sc_res = A & B;
      OP_OR:   sc_res = A | B;
      OP_XOR:  sc_res = A ^ B;
      OP_NOR:  sc_res = ~(A | B);
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLL:  sc_res = A << shamt;
      OP_SRL:  sc_res = A >> shamt;
      OP_SRA:  sc_res = $signed(A) >>> shamt;
      OP_MUL, OP_DIV: sc_res = '0;
      default: sc_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    dbz_d   = dbz_q;
    ill_d   = ill_q;
    zero_d  = zero_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (accept) begin
          if (aluctl == OP_MUL || (aluctl == OP_DIV && B != '0)) begin
            opa_d   = abs_a;
            opb_d   = abs_b;
            acc_d   = '0;
            cnt_d   = '0;
            neg_d   = A[WIDTH-1] ^ B[WIDTH-1];
            state_d = (aluctl == OP_MUL) ? S_MUL : S_DIV;
          end else if (aluctl == OP_DIV) begin
            res_d   = '1;
            ovf_d   = 1'b0;
            dbz_d   = 1'b1;
            ill_d   = 1'b0;
            zero_d  = 1'b0;
            state_d = S_DONE;
          end else begin
            res_d   = sc_res;
            ovf_d   = sc_ovf;
            dbz_d   = 1'b0;
            ill_d   = sc_ill;
            zero_d  = (sc_res == '0);
            state_d = S_DONE;
          end
        end
      end
      S_MUL: begin
        acc_d = {1'b0, madd};
        opa_d = opa_q << 1;
        opb_d = opb_q >> 1;
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          res_d   = mres;
          ovf_d   = 1'b0;
          dbz_d   = 1'b0;
          ill_d   = 1'b0;
          zero_d  = (mres == '0);
          state_d = S_DONE;
        end
      end
      S_DIV: begin
        acc_d = ge ? rem_dif : rem_sh;
        opa_d = {opa_q[WIDTH-2:0], ge};
        cnt_d = cnt_q + 1'b1;
        if (last) state_d = S_FIX;
      end
      S_FIX: begin
        res_d   = fres;
        ovf_d   = 1'b0;
        dbz_d   = 1'b0;
        ill_d   = 1'b0;
        zero_d  = (fres == '0);
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= S_IDLE;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      dbz_q   <= 1'b0;
      ill_q   <= 1'b0;
      zero_q  <= 1'b0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      dbz_q   <= dbz_d;
      ill_q   <= ill_d;
      zero_q  <= zero_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
    end
  end

  assign alu_out_data = res_q;
  assign alu_ready    = (state_q == S_DONE);
  assign busy         = (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIX);
  assign overflow     = ovf_q;
  assign div_by_zero  = dbz_q;
  assign illegal_op   = ill_q;
  assign zero         = zero_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed-vector bench for multicycle_alu: one task per scenario, inline checks.
`timescale 1ns/1ps
module tb_multicycle_alu;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  aluctl = '0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [31:0] alu_out_data;
  logic        alu_ready, busy, overflow, div_by_zero, illegal_op, zero;

  int n_vec = 0;
  int n_err = 0;

  multicycle_alu #(.WIDTH(32)) dut (
    .clk(clk), .rst_b(rst_b), .start(start), .aluctl(aluctl), .A(A), .B(B),
    .alu_out_data(alu_out_data), .alu_ready(alu_ready), .busy(busy),
    .overflow(overflow), .div_by_zero(div_by_zero), .illegal_op(illegal_op),
    .zero(zero)
  );

  always #5 clk = ~clk;

  // Drive a one-cycle start; returns #1 after the accepting edge.
  task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; aluctl = op; A = a; B = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_ready(output int cyc);
    cyc = 1;
    while (alu_ready !== 1'b1 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({alu_ready, busy, overflow, div_by_zero, illegal_op, zero, alu_out_data} !== 38'd0) begin
      $display("FAIL reset_outputs: got rdy=%b busy=%b data=%h flags=%b%b%b%b, want all 0",
               alu_ready, busy, alu_out_data, overflow, div_by_zero, illegal_op, zero);
      n_err++;
    end
    rst_b = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_addsub();
    issue(6'd0, 32'h7FFFFFFF, 32'h1);
    n_vec++;
    if ({alu_ready, alu_out_data, overflow, zero} !== {1'b1, 32'h80000000, 1'b1, 1'b0}) begin
      $display("FAIL add_ovf: got rdy=%b data=%h ovf=%b z=%b, want 1 80000000 1 0",
               alu_ready, alu_out_data, overflow, zero);
      n_err++;
    end
    issue(6'd1, 32'h7FFFFFFF, 32'h1);
    n_vec++;
    if ({alu_ready, alu_out_data, overflow} !== {1'b1, 32'h80000000, 1'b0}) begin
      $display("FAIL addu_noovf: got rdy=%b data=%h ovf=%b, want 1 80000000 0",
               alu_ready, alu_out_data, overflow);
      n_err++;
    end
    issue(6'd2, 32'h80000000, 32'h1);
    n_vec++;
    if ({alu_ready, alu_out_data, overflow} !== {1'b1, 32'h7FFFFFFF, 1'b1}) begin
      $display("FAIL sub_ovf: got rdy=%b data=%h ovf=%b, want 1 7fffffff 1",
               alu_ready, alu_out_data, overflow);
      n_err++;
    end
    issue(6'd3, 32'h80000000, 32'h1);
    n_vec++;
    if ({alu_ready, alu_out_data, overflow} !== {1'b1, 32'h7FFFFFFF, 1'b0}) begin
      $display("FAIL subu_noovf: got rdy=%b data=%h ovf=%b, want 1 7fffffff 0",
               alu_ready, alu_out_data, overflow);
      n_err++;
    end
    @(posedge clk); #1;
    n_vec++;
    if ({alu_ready, alu_out_data} !== {1'b0, 32'h7FFFFFFF}) begin
      $display("FAIL ready_pulse_hold: got rdy=%b data=%h, want 0 7fffffff", alu_ready, alu_out_data);
      n_err++;
    end
  endtask

  task automatic test_mul();
    int cyc;
    issue(6'd12, 32'hFFFFFFFD, 32'h7);
    A = '0; B = '0; aluctl = 6'd0;
    n_vec++;
    if (busy !== 1'b1) begin
      $display("FAIL mul_busy: got busy=%b, want 1", busy);
      n_err++;
    end
    cyc = 1;
    while (alu_ready !== 1'b1 && cyc < 100) begin
      start = (cyc == 5 || cyc == 20);
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    n_vec++;
    if (cyc !== 33) begin
      $display("FAIL mul_latency: got %0d cycles, want 33", cyc);
      n_err++;
    end
    n_vec++;
    if ({alu_out_data, zero, busy} !== {32'hFFFFFFEB, 1'b0, 1'b0}) begin
      $display("FAIL mul_result: got data=%h z=%b busy=%b, want ffffffeb 0 0",
               alu_out_data, zero, busy);
      n_err++;
    end
    @(posedge clk); #1;
    n_vec++;
    if ({alu_ready, busy} !== 2'b00) begin
      $display("FAIL mul_no_extra_ready: got rdy=%b busy=%b, want 0 0", alu_ready, busy);
      n_err++;
    end
    issue(6'd12, 32'h00010000, 32'h00010000);
    wait_ready(cyc);
    n_vec++;
    if ({alu_ready, alu_out_data, zero} !== {1'b1, 32'h0, 1'b1}) begin
      $display("FAIL mul_truncate: got rdy=%b data=%h z=%b, want 1 00000000 1",
               alu_ready, alu_out_data, zero);
      n_err++;
    end
  endtask

  task automatic test_div();
    int cyc;
    issue(6'd13, 32'hFFFFFFF9, 32'h2);
    wait_ready(cyc);
    n_vec++;
    if (cyc !== 34) begin
      $display("FAIL div_latency: got %0d cycles, want 34", cyc);
      n_err++;
    end
    n_vec++;
    if ({alu_out_data, div_by_zero} !== {32'hFFFFFFFD, 1'b0}) begin
      $display("FAIL div_result: got data=%h dbz=%b, want fffffffd 0", alu_out_data, div_by_zero);
      n_err++;
    end
    @(posedge clk); #1;
    issue(6'd13, 32'h5, 32'h0);
    n_vec++;
    if ({alu_ready, alu_out_data, div_by_zero, busy} !== {1'b1, 32'hFFFFFFFF, 1'b1, 1'b0}) begin
      $display("FAIL div_by_zero: got rdy=%b data=%h dbz=%b busy=%b, want 1 ffffffff 1 0",
               alu_ready, alu_out_data, div_by_zero, busy);
      n_err++;
    end
    issue(6'd13, 32'h80000000, 32'hFFFFFFFF);
    wait_ready(cyc);
    n_vec++;
    if ({alu_ready, alu_out_data, div_by_zero, overflow} !== {1'b1, 32'h80000000, 1'b0, 1'b0}) begin
      $display("FAIL div_minint: got rdy=%b data=%h dbz=%b ovf=%b, want 1 80000000 0 0",
               alu_ready, alu_out_data, div_by_zero, overflow);
      n_err++;
    end
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    issue(6'd0, 32'h1, 32'h1);
    n_vec++;
    if ({alu_ready, alu_out_data} !== {1'b1, 32'h2}) begin
      $display("FAIL b2b_add: got rdy=%b data=%h, want 1 00000002", alu_ready, alu_out_data);
      n_err++;
    end
    issue(6'd9, 32'h1, 32'h0000003F);
    n_vec++;
    if ({alu_ready, alu_out_data} !== {1'b1, 32'h80000000}) begin
      $display("FAIL b2b_sll: got rdy=%b data=%h, want 1 80000000", alu_ready, alu_out_data);
      n_err++;
    end
    issue(6'd11, 32'h80000000, 32'h4);
    n_vec++;
    if ({alu_ready, alu_out_data} !== {1'b1, 32'hF8000000}) begin
      $display("FAIL b2b_sra: got rdy=%b data=%h, want 1 f8000000", alu_ready, alu_out_data);
      n_err++;
    end
    issue(6'd10, 32'h80000000, 32'h4);
    n_vec++;
    if ({alu_ready, alu_out_data} !== {1'b1, 32'h08000000}) begin
      $display("FAIL b2b_srl: got rdy=%b data=%h, want 1 08000000", alu_ready, alu_out_data);
      n_err++;
    end
    issue(6'd8, 32'hFFFFFFFF, 32'h0);
    n_vec++;
    if ({alu_ready, alu_out_data, zero} !== {1'b1, 32'h1, 1'b0}) begin
      $display("FAIL b2b_slt: got rdy=%b data=%h z=%b, want 1 00000001 0",
               alu_ready, alu_out_data, zero);
      n_err++;
    end
    issue(6'd7, 32'h0F0F0000, 32'h000000F0);
    n_vec++;
    if ({alu_ready, alu_out_data} !== {1'b1, 32'hF0F0FF0F}) begin
      $display("FAIL b2b_nor: got rdy=%b data=%h, want 1 f0f0ff0f", alu_ready, alu_out_data);
      n_err++;
    end
  endtask

  task automatic test_reset_mid_div();
    logic seen;
    issue(6'd13, 32'd100, 32'd7);
    repeat (9) begin @(posedge clk); #1; end
    n_vec++;
    if (busy !== 1'b1) begin
      $display("FAIL mid_div_busy: got busy=%b, want 1", busy);
      n_err++;
    end
    rst_b = 1'b0;
    #1;
    n_vec++;
    if ({alu_ready, busy, overflow, div_by_zero, illegal_op, zero, alu_out_data} !== 38'd0) begin
      $display("FAIL mid_div_reset: got rdy=%b busy=%b data=%h, want all 0",
               alu_ready, busy, alu_out_data);
      n_err++;
    end
    @(posedge clk); #1;
    rst_b = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (alu_ready === 1'b1) seen = 1'b1;
    end
    n_vec++;
    if (seen !== 1'b0) begin
      $display("FAIL mid_div_no_ready: got ready pulse=%b, want 0", seen);
      n_err++;
    end
    issue(6'd0, 32'd2, 32'd3);
    n_vec++;
    if ({alu_ready, alu_out_data, zero} !== {1'b1, 32'd5, 1'b0}) begin
      $display("FAIL post_reset_add: got rdy=%b data=%h z=%b, want 1 00000005 0",
               alu_ready, alu_out_data, zero);
      n_err++;
    end
    issue(6'd63, 32'h12345678, 32'h9ABCDEF0);
    n_vec++;
    if ({alu_ready, alu_out_data, illegal_op, zero, overflow} !== {1'b1, 32'h0, 1'b1, 1'b1, 1'b0}) begin
      $display("FAIL illegal_op: got rdy=%b data=%h ill=%b z=%b ovf=%b, want 1 00000000 1 1 0",
               alu_ready, alu_out_data, illegal_op, zero, overflow);
      n_err++;
    end
  endtask

  initial begin
    test_reset();
    test_addsub();
    test_mul();
    test_div();
    test_back_to_back();
    test_reset_mid_div();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
